term_cfg_relay: RTL and testbench
=================================

# term_cfg_relay

Parametrised successor to the single-span south termination tile. It loops back edge routing wires with configurable channel widths, and relays the configuration column (FrameData/FrameStrobe) through a retiming pipeline so tall fabrics meet timing on the config path. It also provides compile-time-optional strobe statistics: a frame-write counter and a sticky multi-hot-strobe error. It sits at the bottom of every fabric column, between the column's config chain and the lowest logic tile.

## Interface
Parameters:
- FRAME_BITS, 32, FrameData width
- MAX_FRAMES, 20, FrameStrobe width
- PIPE_STAGES, 1, config-path register stages, legal 0..4; 0 = pure wire
- SINGLE_W, 4, width of single-span wires
- DOUBLE_W, 8, width of double-span wires
- QUAD_W, 16, width of quad-span wires
- CNT_W, 16, frame counter width

Ports:
- CLK  in  1  configuration clock; all flops are rising-edge
- resetn  in  1  synchronous active-low reset
- FrameData  in  FRAME_BITS  config data from the column above
- FrameData_O  out  FRAME_BITS  delayed FrameData
- FrameStrobe  in  MAX_FRAMES  frame strobes
- FrameStrobe_O  out  MAX_FRAMES  delayed FrameStrobe
- S1END  in  SINGLE_W; S2MID, S2END  in  DOUBLE_W each; S4END, SS4END  in  QUAD_W each
- N1BEG  out  SINGLE_W; N2BEG, N2BEGb  out  DOUBLE_W each; N4BEG, NN4BEG  out  QUAD_W each
- stat_clr  in  1  synchronous clear of the statistics
- frame_cnt  out  CNT_W  frame-write events seen
- strobe_err  out  1  sticky flag: more than one strobe bit was high in one cycle

## Operation
- Routing loop-back is combinational with no config bits:
  - N1BEG=S1END
  - N2BEG=S2MID
  - N2BEGb=S2END
  - N4BEG=S4END
  - NN4BEG=SS4END
- Config relay:
  - FrameData and FrameStrobe pass through identical PIPE_STAGES-deep delay lines, so data and strobe stay cycle-aligned.
  - Every stage resets to all-zero, so reset can never produce a spurious strobe.
- Frame event: a cycle in which FrameStrobe_O is non-zero. Sampling at the output side means stats match what downstream tiles actually receive.
- frame_cnt:
  - Increments by 1 on each frame event.
  - Saturates at 2^CNT_W-1; no wrap.
- strobe_err:
  - Set when popcount(FrameStrobe_O) > 1.
  - Stays set until stat_clr or reset.
- stat_clr, when asserted:
  - frame_cnt goes to 0, or to 1 if a frame event occurs in the same cycle.
  - strobe_err goes to 0, or to 1 if a multi-hot event occurs in the same cycle. Event wins over clear.
- Reset mid-frame flushes the pipeline. In-flight frames are dropped, and the config controller must restart the bitstream.
- PIPE_STAGES outside 0..4 is an elaboration error.

## Timing
- FrameData_O/FrameStrobe_O equal the inputs from PIPE_STAGES cycles earlier; zero-latency when PIPE_STAGES=0.
- frame_cnt and strobe_err are registered: they reflect an output-side event one cycle after it appears on FrameStrobe_O.
- Values during resetn=0 and in the first cycle after it: FrameData_O=0, FrameStrobe_O=0 (PIPE_STAGES>0), frame_cnt=0, strobe_err=0.
- With PIPE_STAGES=0, outputs follow the inputs even in reset.
- Routing outputs have no reset; they are wires.

## Configuration
- TERM_RELAY_STATS_EN defined: the counter, popcount and error logic are built.
- Undefined:
  - frame_cnt and strobe_err are tied to 0, and stat_clr is ignored.
  - No statistic flops exist.
  - The relay and loop-back are unchanged.

## Structure
- Package term_relay_pkg holds:
  - PIPE_MAX=4
  - default wire widths
  - a popcount-greater-than-one function, shared with future edge tiles
- Sub-module cfg_delay_line (parameters WIDTH, DEPTH; ports CLK, resetn, d, q) is instantiated twice, once for data and once for strobe.
- The top level holds the loop-back assigns and the stats logic.

## Test plan
- PIPE_STAGES=2, FrameData=0xA5A5_0001 with FrameStrobe=0x00001 for 1 cycle -> same values on outputs exactly 2 cycles later; frame_cnt=1 one cycle after that; strobe_err=0.
- FrameStrobe=0x00003 for one cycle -> strobe_err=1 and stays 1 through 10 idle cycles; stat_clr -> strobe_err=0, frame_cnt=0.
- CNT_W=4, 20 single-hot strobes -> frame_cnt saturates at 15.
- stat_clr asserted in the same cycle as an output frame event -> frame_cnt=1 next cycle.
- resetn low while a strobe is mid-pipeline (PIPE_STAGES=3) -> FrameStrobe_O never pulses; all outputs 0 the cycle after reset.
- Random S*END values with PIPE_STAGES=0 -> N*BEG equal the corresponding inputs in the same cycle; FrameData_O equals FrameData combinationally.
- Build without TERM_RELAY_STATS_EN -> frame_cnt and strobe_err remain 0 under the stimulus above.

Source files
------------

// File: rtl/term_relay_pkg.sv
// rtl/term_relay_pkg.sv - shared constants and helpers for south-edge termination tiles
//   PIPE_MAX      : deepest legal config-path retiming pipeline
//   *_W_DEF       : default routing channel widths
//   POP_MAX_W     : widest strobe vector accepted by popcount_gt1
//   popcount_gt1  : true when more than one bit of the (zero-extended) vector is set
package term_relay_pkg;

  localparam int PIPE_MAX     = 4;
  localparam int SINGLE_W_DEF = 4;
  localparam int DOUBLE_W_DEF = 8;
  localparam int QUAD_W_DEF   = 16;
  localparam int POP_MAX_W    = 256;

  // x & (x-1) clears the lowest set bit; anything left over means a second bit was set.
  function automatic logic popcount_gt1(input logic [POP_MAX_W-1:0] x);
    return |(x & (x - POP_MAX_W'(1)));
  endfunction

endpackage

// File: rtl/cfg_delay_line.sv
// rtl/cfg_delay_line.sv - resettable DEPTH-stage delay line for the config column
//   WIDTH  : bits per stage
//   DEPTH  : number of register stages; 0 makes q a plain wire
//   CLK    : in  configuration clock (rising edge)
//   resetn : in  synchronous active-low reset, clears every stage to zero
//   d      : in  WIDTH  value entering the line
//   q      : out WIDTH  d delayed by DEPTH cycles
module cfg_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ resetn;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Zero reset on every stage, so a reset mid-frame can never emit a strobe.
    always_ff @(posedge CLK) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!resetn) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/term_cfg_relay.sv
// rtl/term_cfg_relay.sv - south termination tile: routing loop-back, retimed config relay, strobe stats
//   Optional feature macro: TERM_RELAY_STATS_EN (frame counter and multi-hot strobe error)
//   CLK           : in   configuration clock, rising edge
//   resetn        : in   synchronous active-low reset
//   FrameData     : in   FRAME_BITS  config data from the column above
//   FrameData_O   : out  FRAME_BITS  FrameData delayed PIPE_STAGES cycles
//   FrameStrobe   : in   MAX_FRAMES  frame strobes
//   FrameStrobe_O : out  MAX_FRAMES  FrameStrobe delayed PIPE_STAGES cycles
//   S1END/S2MID/S2END/S4END/SS4END : in   south routing wire ends
//   N1BEG/N2BEG/N2BEGb/N4BEG/NN4BEG: out  looped-back north wire begins
//   stat_clr      : in   synchronous clear of frame_cnt and strobe_err
//   frame_cnt     : out  CNT_W  saturating count of output-side frame events
//   strobe_err    : out  sticky multi-hot strobe flag
module term_cfg_relay
  import term_relay_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int MAX_FRAMES  = 20,
  parameter int PIPE_STAGES = 1,
  parameter int SINGLE_W    = SINGLE_W_DEF,
  parameter int DOUBLE_W    = DOUBLE_W_DEF,
  parameter int QUAD_W      = QUAD_W_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic [FRAME_BITS-1:0] FrameData,
  output logic [FRAME_BITS-1:0] FrameData_O,
  input  logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic [MAX_FRAMES-1:0] FrameStrobe_O,
  input  logic [SINGLE_W-1:0]   S1END,
  input  logic [DOUBLE_W-1:0]   S2MID,
  input  logic [DOUBLE_W-1:0]   S2END,
  input  logic [QUAD_W-1:0]     S4END,
  input  logic [QUAD_W-1:0]     SS4END,
  output logic [SINGLE_W-1:0]   N1BEG,
  output logic [DOUBLE_W-1:0]   N2BEG,
  output logic [DOUBLE_W-1:0]   N2BEGb,
  output logic [QUAD_W-1:0]     N4BEG,
  output logic [QUAD_W-1:0]     NN4BEG,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  strobe_err
);

  if (PIPE_STAGES < 0 || PIPE_STAGES > PIPE_MAX) begin : g_bad_pipe
    $error("term_cfg_relay: PIPE_STAGES must be within 0..%0d", PIPE_MAX);
  end
  if (MAX_FRAMES > POP_MAX_W) begin : g_bad_frames
    $error("term_cfg_relay: MAX_FRAMES exceeds popcount helper width");
  end

  // Routing loop-back: pure wires, no configuration.
  assign N1BEG  = S1END;
  assign N2BEG  = S2MID;
  assign N2BEGb = S2END;
  assign N4BEG  = S4END;
  assign NN4BEG = SS4END;

  // Data and strobe use identical delay lines so they stay cycle-aligned.
  cfg_delay_line #(.WIDTH(FRAME_BITS), .DEPTH(PIPE_STAGES)) u_data_dly (
    .CLK    (CLK),
    .resetn (resetn),
    .d      (FrameData),
    .q      (FrameData_O)
  );

  cfg_delay_line #(.WIDTH(MAX_FRAMES), .DEPTH(PIPE_STAGES)) u_strobe_dly (
    .CLK    (CLK),
    .resetn (resetn),
    .d      (FrameStrobe),
    .q      (FrameStrobe_O)
  );

`ifdef TERM_RELAY_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             strobe_err_q, strobe_err_d;
  logic             frame_evt, multi_evt;

  // Statistics are taken on the output side so they describe what downstream tiles see.
  always_comb begin
    frame_evt    = |FrameStrobe_O;
    multi_evt    = popcount_gt1(POP_MAX_W'(FrameStrobe_O));
    frame_cnt_d  = frame_cnt_q;
    strobe_err_d = strobe_err_q;
    if (stat_clr) begin
      frame_cnt_d  = '0;
      strobe_err_d = 1'b0;
    end
    // Applied after the clear so a same-cycle event survives it.
    if (frame_evt && (frame_cnt_d != {CNT_W{1'b1}})) begin
      frame_cnt_d = frame_cnt_d + CNT_W'(1);
    end
    if (multi_evt) begin
      strobe_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      frame_cnt_q  <= '0;
      strobe_err_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign strobe_err = strobe_err_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign frame_cnt       = '0;
  assign strobe_err      = 1'b0;
`endif

endmodule

// File: tb/tb_term_cfg_relay.sv
// tb/tb_term_cfg_relay.sv - scoreboard bench for term_cfg_relay (PIPE_STAGES 2, 3 and 0 instances)
module tb_term_cfg_relay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // shared routing inputs
  logic [3:0]  s1;
  logic [7:0]  s2m, s2e;
  logic [15:0] s4, ss4;

  // dut2: PIPE_STAGES=2, CNT_W=4
  logic [31:0] fd2, fdo2;
  logic [19:0] fs2, fso2;
  logic        clr2, err2;
  logic [3:0]  cnt2;
  logic [3:0]  n1_2;
  logic [7:0]  n2_2, n2b_2;
  logic [15:0] n4_2, nn4_2;

  // dut3: PIPE_STAGES=3
  logic [31:0] fd3, fdo3;
  logic [19:0] fs3, fso3;
  logic        clr3, err3;
  logic [15:0] cnt3;
  logic [3:0]  n1_3;
  logic [7:0]  n2_3, n2b_3;
  logic [15:0] n4_3, nn4_3;

  // dut0: PIPE_STAGES=0
  logic [31:0] fd0, fdo0;
  logic [19:0] fs0, fso0;
  logic        clr0, err0;
  logic [15:0] cnt0;
  logic [3:0]  n1_0;
  logic [7:0]  n2_0, n2b_0;
  logic [15:0] n4_0, nn4_0;

  term_cfg_relay #(.PIPE_STAGES(2), .CNT_W(4)) dut2 (
    .CLK(clk), .resetn(resetn), .FrameData(fd2), .FrameData_O(fdo2),
    .FrameStrobe(fs2), .FrameStrobe_O(fso2),
    .S1END(s1), .S2MID(s2m), .S2END(s2e), .S4END(s4), .SS4END(ss4),
    .N1BEG(n1_2), .N2BEG(n2_2), .N2BEGb(n2b_2), .N4BEG(n4_2), .NN4BEG(nn4_2),
    .stat_clr(clr2), .frame_cnt(cnt2), .strobe_err(err2)
  );

  term_cfg_relay #(.PIPE_STAGES(3), .CNT_W(16)) dut3 (
    .CLK(clk), .resetn(resetn), .FrameData(fd3), .FrameData_O(fdo3),
    .FrameStrobe(fs3), .FrameStrobe_O(fso3),
    .S1END(s1), .S2MID(s2m), .S2END(s2e), .S4END(s4), .SS4END(ss4),
    .N1BEG(n1_3), .N2BEG(n2_3), .N2BEGb(n2b_3), .N4BEG(n4_3), .NN4BEG(nn4_3),
    .stat_clr(clr3), .frame_cnt(cnt3), .strobe_err(err3)
  );

  term_cfg_relay #(.PIPE_STAGES(0), .CNT_W(16)) dut0 (
    .CLK(clk), .resetn(resetn), .FrameData(fd0), .FrameData_O(fdo0),
    .FrameStrobe(fs0), .FrameStrobe_O(fso0),
    .S1END(s1), .S2MID(s2m), .S2END(s2e), .S4END(s4), .SS4END(ss4),
    .N1BEG(n1_0), .N2BEG(n2_0), .N2BEGb(n2b_0), .N4BEG(n4_0), .NN4BEG(nn4_0),
    .stat_clr(clr0), .frame_cnt(cnt0), .strobe_err(err0)
  );

  int  errors = 0;
  int  checks = 0;
  bit  stats_en;

  // scoreboard for dut2: {data, strobe} expected on the outputs PIPE_STAGES cycles later
  logic [51:0] sb_q[$];
  logic [31:0] exp_d;
  logic [19:0] exp_s;
  logic [3:0]  exp_cnt, mdl_cnt;
  logic        exp_err, mdl_err;

  task automatic init_model2();
    sb_q.delete();
    sb_q.push_back(52'd0);
    sb_q.push_back(52'd0);
    mdl_cnt = 4'd0;
    mdl_err = 1'b0;
  endtask

  // Drive one cycle into dut2, pop the expected outputs for this cycle and advance the stats model.
  task automatic tick2(input logic [31:0] d, input logic [19:0] s, input logic clr);
    logic [51:0] e;
    @(negedge clk);
    fd2  = d;
    fs2  = s;
    clr2 = clr;
    sb_q.push_back({d, s});
    #1;
    e       = sb_q.pop_front();
    exp_d   = e[51:20];
    exp_s   = e[19:0];
    exp_cnt = stats_en ? mdl_cnt : 4'd0;
    exp_err = stats_en ? mdl_err : 1'b0;
    if (clr) begin
      mdl_cnt = 4'd0;
      mdl_err = 1'b0;
    end
    if (exp_s != 20'd0 && mdl_cnt != 4'hF) mdl_cnt = mdl_cnt + 4'd1;
    if ($countones(exp_s) > 1) mdl_err = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    fd2 = 32'hFFFF_FFFF; fs2 = 20'hFFFFF; clr2 = 1'b0;
    fd3 = 32'hFFFF_FFFF; fs3 = 20'hFFFFF; clr3 = 1'b0;
    fd0 = 32'h1234_5678; fs0 = 20'h00000; clr0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fdo2 !== 32'd0) begin errors++; $display("FAIL reset_data2 got=%h exp=0", fdo2); end
    checks++; if (fso2 !== 20'd0) begin errors++; $display("FAIL reset_strobe2 got=%h exp=0", fso2); end
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err2 got=%b exp=0", err2); end
    checks++; if (fso3 !== 20'd0) begin errors++; $display("FAIL reset_strobe3 got=%h exp=0", fso3); end
    checks++; if (fdo0 !== 32'h1234_5678) begin errors++; $display("FAIL reset_wire0 got=%h exp=12345678", fdo0); end
    resetn = 1'b1;
    fd2 = 32'd0; fs2 = 20'd0;
    fd3 = 32'd0; fs3 = 20'd0;
    init_model2();
    for (int i = 0; i < 3; i++) begin
      tick2(32'd0, 20'd0, 1'b0);
      checks++; if (fdo2 !== exp_d) begin errors++; $display("FAIL post_reset_data got=%h exp=%h", fdo2, exp_d); end
      checks++; if (fso2 !== exp_s) begin errors++; $display("FAIL post_reset_strobe got=%h exp=%h", fso2, exp_s); end
      checks++; if (cnt2 !== exp_cnt) begin errors++; $display("FAIL post_reset_cnt got=%0d exp=%0d", cnt2, exp_cnt); end
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d_tab [6] = '{32'hA5A5_0001, 0, 0, 0, 0, 0};
    logic [19:0] s_tab [6] = '{20'h00001, 0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      tick2(d_tab[i], s_tab[i], 1'b0);
      checks++; if (fdo2 !== exp_d) begin errors++; $display("FAIL single_data c%0d got=%h exp=%h", i, fdo2, exp_d); end
      checks++; if (fso2 !== exp_s) begin errors++; $display("FAIL single_strobe c%0d got=%h exp=%h", i, fso2, exp_s); end
      checks++; if (cnt2 !== exp_cnt) begin errors++; $display("FAIL single_cnt c%0d got=%0d exp=%0d", i, cnt2, exp_cnt); end
      checks++; if (err2 !== exp_err) begin errors++; $display("FAIL single_err c%0d got=%b exp=%b", i, err2, exp_err); end
    end
    checks++; if (cnt2 !== (stats_en ? 4'd1 : 4'd0)) begin errors++; $display("FAIL single_final_cnt got=%0d exp=%0d", cnt2, stats_en ? 1 : 0); end
  endtask

  task automatic test_multi_hot();
    for (int i = 0; i < 16; i++) begin
      tick2(32'h0000_0F0F, (i == 0) ? 20'h00003 : 20'h00000, (i == 13) ? 1'b1 : 1'b0);
      checks++; if (fso2 !== exp_s) begin errors++; $display("FAIL multi_strobe c%0d got=%h exp=%h", i, fso2, exp_s); end
      checks++; if (cnt2 !== exp_cnt) begin errors++; $display("FAIL multi_cnt c%0d got=%0d exp=%0d", i, cnt2, exp_cnt); end
      checks++; if (err2 !== exp_err) begin errors++; $display("FAIL multi_err c%0d got=%b exp=%b", i, err2, exp_err); end
    end
    checks++; if (err2 !== 1'b0 || cnt2 !== 4'd0) begin errors++; $display("FAIL multi_cleared got err=%b cnt=%0d exp err=0 cnt=0", err2, cnt2); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 24; i++) begin
      tick2(32'(i), (i < 20) ? (20'd1 << (i % 20)) : 20'd0, 1'b0);
      checks++; if (fso2 !== exp_s) begin errors++; $display("FAIL sat_strobe c%0d got=%h exp=%h", i, fso2, exp_s); end
      checks++; if (cnt2 !== exp_cnt) begin errors++; $display("FAIL sat_cnt c%0d got=%0d exp=%0d", i, cnt2, exp_cnt); end
      checks++; if (err2 !== exp_err) begin errors++; $display("FAIL sat_err c%0d got=%b exp=%b", i, err2, exp_err); end
    end
    checks++; if (cnt2 !== (stats_en ? 4'd15 : 4'd0)) begin errors++; $display("FAIL sat_final got=%0d exp=%0d", cnt2, stats_en ? 15 : 0); end
  endtask

  task automatic test_clr_with_event();
    // the strobe driven in cycle 0 reaches the output in cycle 2, together with stat_clr
    for (int i = 0; i < 5; i++) begin
      tick2(32'h0BAD_F00D, (i == 0) ? 20'h00010 : 20'h00000, (i == 2) ? 1'b1 : 1'b0);
      checks++; if (fso2 !== exp_s) begin errors++; $display("FAIL clr_evt_strobe c%0d got=%h exp=%h", i, fso2, exp_s); end
      checks++; if (cnt2 !== exp_cnt) begin errors++; $display("FAIL clr_evt_cnt c%0d got=%0d exp=%0d", i, cnt2, exp_cnt); end
    end
    checks++; if (cnt2 !== (stats_en ? 4'd1 : 4'd0)) begin errors++; $display("FAIL clr_evt_final got=%0d exp=%0d", cnt2, stats_en ? 1 : 0); end
  endtask

  task automatic test_reset_midpipe();
    @(negedge clk);
    fd2 = 32'd0; fs2 = 20'd0; clr2 = 1'b0;
    fd3 = 32'hDEAD_BEEF; fs3 = 20'h00001;
    @(negedge clk);
    fd3 = 32'd0; fs3 = 20'd0;
    resetn = 1'b0;
    #1;
    checks++; if (fso3 !== 20'd0) begin errors++; $display("FAIL midpipe_pre got=%h exp=0", fso3); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (fdo3 !== 32'd0) begin errors++; $display("FAIL midpipe_data got=%h exp=0", fdo3); end
    checks++; if (cnt3 !== 16'd0 || err3 !== 1'b0) begin errors++; $display("FAIL midpipe_stats got cnt=%0d err=%b exp 0/0", cnt3, err3); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++; if (fso3 !== 20'd0) begin errors++; $display("FAIL midpipe_strobe c%0d got=%h exp=0", i, fso3); end
      checks++; if (fdo3 !== 32'd0) begin errors++; $display("FAIL midpipe_dout c%0d got=%h exp=0", i, fdo3); end
    end
    checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL midpipe_cnt got=%0d exp=0", cnt3); end
    init_model2();
  endtask

  task automatic test_routing();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s1  = 4'($urandom);
      s2m = 8'($urandom);
      s2e = 8'($urandom);
      s4  = 16'($urandom);
      ss4 = 16'($urandom);
      fd0 = $urandom;
      fs0 = 20'($urandom);
      #1;
      checks++; if (n1_0 !== s1) begin errors++; $display("FAIL route_n1 got=%h exp=%h", n1_0, s1); end
      checks++; if (n2_0 !== s2m) begin errors++; $display("FAIL route_n2 got=%h exp=%h", n2_0, s2m); end
      checks++; if (n2b_0 !== s2e) begin errors++; $display("FAIL route_n2b got=%h exp=%h", n2b_0, s2e); end
      checks++; if (n4_0 !== s4) begin errors++; $display("FAIL route_n4 got=%h exp=%h", n4_0, s4); end
      checks++; if (nn4_0 !== ss4) begin errors++; $display("FAIL route_nn4 got=%h exp=%h", nn4_0, ss4); end
      checks++; if (fdo0 !== fd0) begin errors++; $display("FAIL wire_data0 got=%h exp=%h", fdo0, fd0); end
      checks++; if (fso0 !== fs0) begin errors++; $display("FAIL wire_strobe0 got=%h exp=%h", fso0, fs0); end
    end
  endtask

  initial begin
`ifdef TERM_RELAY_STATS_EN
    stats_en = 1'b1;
`else
    stats_en = 1'b0;
`endif
    resetn = 1'b0;
    s1 = '0; s2m = '0; s2e = '0; s4 = '0; ss4 = '0;
    fd2 = '0; fs2 = '0; clr2 = 1'b0;
    fd3 = '0; fs3 = '0; clr3 = 1'b0;
    fd0 = '0; fs0 = '0; clr0 = 1'b0;
    init_model2();

    test_reset();
    test_single_frame();
    test_multi_hot();
    test_saturate();
    test_clr_with_event();
    test_reset_midpipe();
    test_single_frame();
    test_routing();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
